seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner; new data is committed only at frame boundaries.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
  parameter int unsigned CNT_MAX   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  // CNT_MAX and BLANK_CYC must both be at least 1.
  localparam int unsigned DW = $clog2(CNT_MAX + 1);
  localparam int unsigned BW = $clog2(BLANK_CYC + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(CNT_MAX - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  // Reset asserts asynchronously and is released two clocks after sys_rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          wrap;
  logic [31:0]   stage_data_q, stage_data_d, shadow_data_q, shadow_data_d;
  logic [7:0]    stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic          commit;
  logic [7:0]    sel_d, seg_d;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      dwell_d = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = 3'd0;
          dwell_d = '0;
          blank_d = '0;
        end
        SHOW: begin
          if (dwell_q == DWELL_LAST) begin
            state_d = BLANK;
            dwell_d = '0;
            blank_d = '0;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_d = SHOW;
            blank_d = '0;
            idx_d   = idx_q + 3'd1;
            wrap    = (idx_q == 3'd7);
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow only changes at a frame wrap or while idle; a coincident load bypasses staging.
  always_comb begin
    stage_data_d  = load ? data_in : stage_data_q;
    stage_dp_d    = load ? dp_in : stage_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    commit        = wrap || (state_q == IDLE);
    if (commit) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_data_d = data_in;
        shadow_dp_d   = dp_in;
      end else if (pending_q) begin
        shadow_data_d = stage_data_q;
        shadow_dp_d   = stage_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    sel_d  = 8'hFF;
    seg_d  = 8'hFF;
    nibble = shadow_data_d[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW) begin
      sel_d = ~(8'h01 << idx_d);
      seg_d = {~shadow_dp_d[idx_d], hex7(nibble)};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if ((idx_d != 3'd0) && ((shadow_data_d >> {idx_d, 2'b00}) == 32'd0)) begin
        seg_d[6:0] = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      dwell_q       <= '0;
      blank_q       <= '0;
      stage_data_q  <= 32'd0;
      stage_dp_q    <= 8'd0;
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      pending_q     <= 1'b0;
      sel           <= 8'hFF;
      seg           <= 8'hFF;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dwell_q       <= dwell_d;
      blank_q       <= blank_d;
      stage_data_q  <= stage_data_d;
      stage_dp_q    <= stage_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      sel           <= sel_d;
      seg           <= seg_d;
      frame_done    <= wrap;
    end
  end

endmodule
